// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator-side sequencer for the 8-bit memory port.
// Accepts single writes and 1-4 beat incrementing read bursts on a
// valid/ready request channel. It waits READ_LATENCY cycles per read beat
// and returns data on a valid/ready response channel.
// Optional feature macro: MEM_ACCESS_BOUNDS_EN (rejects requests whose last
// address exceeds ADDR_LIMIT with a single rsp_err response).
module mem_access_ctrl #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [7:0]  ADDR_LIMIT   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [1:0] req_len,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic       rsp_err,
  output logic [7:0] mem_address,
  output logic [7:0] mem_data_in,
  output logic       mem_write_enable,
  input  logic [7:0] mem_data_out,
  output logic       busy
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned BW = 3;
  localparam int unsigned LW = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [BW-1:0] beats_q;
  logic [LW-1:0] lat_cnt;

  logic          accept_c;
  logic          rsp_fire_c;
  logic          bounds_err_c;
  logic [BW-1:0] req_beats_c;

  assign req_ready   = (state == IDLE) && !reset;
  assign accept_c    = req_valid && req_ready;
  assign rsp_fire_c  = rsp_valid && rsp_ready;
  assign req_beats_c = req_write ? BW'(1) : (BW'(req_len) + BW'(1));
  assign busy        = (state != IDLE);

`ifdef MEM_ACCESS_BOUNDS_EN
  logic [AW:0] req_end_c;

  // Last address touched by the request, computed without wrap
  assign req_end_c    = {1'b0, req_addr} + (AW+1)'(req_beats_c) - (AW+1)'(1);
  assign bounds_err_c = (req_end_c > {1'b0, ADDR_LIMIT});

  // Error flag is latched once per accepted request and held through RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_err <= 1'b0;
    end else if (accept_c) begin
      rsp_err <= bounds_err_c;
    end
  end
`else
  logic unused_limit;

  assign bounds_err_c = 1'b0;
  assign rsp_err      = 1'b0;
  assign unused_limit = ^ADDR_LIMIT;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          state_nxt = bounds_err_c ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = wr_q ? RESP : WAIT;
      end
      WAIT: begin
        if (lat_cnt == LW'(1)) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_fire_c) begin
          state_nxt = (beats_q > BW'(1)) ? ISSUE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: memory port is loaded on entry to ISSUE so it is valid during ISSUE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q             <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      beats_q          <= '0;
      lat_cnt          <= '0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_last         <= 1'b0;
      mem_address      <= '0;
      mem_data_in      <= '0;
      mem_write_enable <= 1'b0;
    end else begin
      mem_write_enable <= 1'b0;
      rsp_valid        <= (state_nxt == RESP);
      case (state)
        IDLE: begin
          if (accept_c) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            beats_q <= req_beats_c;
            if (bounds_err_c) begin
              beats_q  <= BW'(1);
              rsp_data <= '0;
              rsp_last <= 1'b1;
            end else begin
              mem_address      <= req_addr;
              mem_data_in      <= req_wdata;
              mem_write_enable <= req_write;
            end
          end
        end
        ISSUE: begin
          if (wr_q) begin
            rsp_data <= wdata_q;
            rsp_last <= 1'b1;
          end else begin
            lat_cnt <= LW'(READ_LATENCY);
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - LW'(1);
          if (lat_cnt == LW'(1)) begin
            rsp_data <= mem_data_out;
            rsp_last <= (beats_q == BW'(1));
          end
        end
        RESP: begin
          if (rsp_fire_c) begin
            beats_q <= beats_q - BW'(1);
            if (beats_q > BW'(1)) begin
              addr_q      <= addr_q + AW'(1);
              mem_address <= addr_q + AW'(1);
              mem_data_in <= wdata_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a synchronous 1-cycle memory model.
module tb_mem_access_ctrl;

  localparam int unsigned RL = 1;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [1:0] req_len;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       rsp_err;
  logic [7:0] mem_address;
  logic [7:0] mem_data_in;
  logic       mem_write_enable;
  logic [7:0] mem_data_out;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;

  logic [7:0] mem [0:255];

  mem_access_ctrl #(.READ_LATENCY(RL), .ADDR_LIMIT(8'h7F)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory block: synchronous write, registered read (latency 1)
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  always @(posedge clk) begin
    if (mem_write_enable) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge after the handshake edge
  task automatic send(input logic wr, input logic [7:0] a, input logic [1:0] len, input logic [7:0] d);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = len; req_wdata = d;
    check("req_ready_before_send", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for a response beat, check it, optionally stall, then accept it
  task automatic take(input string tag, input logic [7:0] data, input logic last,
                      input logic err, input logic [7:0] addr, input int stall, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_data"}, 32'(rsp_data), 32'(data));
    check({tag, "_last"}, 32'(rsp_last), 32'(last));
    check({tag, "_err"}, 32'(rsp_err), 32'(err));
    check({tag, "_addr"}, 32'(mem_address), 32'(addr));
    rsp_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_stall_data"}, 32'(rsp_data), 32'(data));
      check({tag, "_stall_addr"}, 32'(mem_address), 32'(addr));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int w0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_len = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(mem_write_enable), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);

    // Single write then read-back, with latency check
    w0 = we_cnt;
    send(1'b1, 8'h10, 2'd0, 8'h3C);
    check("wr_issue_we", 32'(mem_write_enable), 32'd1);
    check("wr_issue_addr", 32'(mem_address), 32'h10);
    check("wr_issue_din", 32'(mem_data_in), 32'h3C);
    take("wr", 8'h3C, 1'b1, 1'b0, 8'h10, 0, lat);
    check("wr_lat", 32'(lat), 32'd1);
    check("wr_we_count", 32'(we_cnt - w0), 32'd1);
    send(1'b0, 8'h10, 2'd0, 8'h00);
    take("rd", 8'h3C, 1'b1, 1'b0, 8'h10, 0, lat);
    check("rd_lat", 32'(lat), 32'(RL + 1));
    check("rd_busy_after", 32'(busy), 32'd0);

    // Preload A0..A3 through the controller
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'(8'h20 + i), 2'd0, 8'(8'hA0 + i));
      take("pre", 8'(8'hA0 + i), 1'b1, 1'b0, 8'(8'h20 + i), 0, lat);
    end

    // Four-beat burst
    w0 = we_cnt;
    send(1'b0, 8'h20, 2'd3, 8'h00);
    for (int i = 0; i < 4; i++) begin
      take("burst", 8'(8'hA0 + i), (i == 3), 1'b0, 8'(8'h20 + i), 0, lat);
    end
    check("burst_busy_after", 32'(busy), 32'd0);

    // Same burst with 5-cycle stall on beat 2
    send(1'b0, 8'h20, 2'd3, 8'h00);
    for (int i = 0; i < 4; i++) begin
      take("stall", 8'(8'hA0 + i), (i == 3), 1'b0, 8'(8'h20 + i), (i == 1) ? 5 : 0, lat);
    end
    repeat (4) @(negedge clk);
    check("stall_no_extra_beat", 32'(rsp_valid), 32'd0);
    check("reads_no_write", 32'(we_cnt - w0), 32'd0);

`ifdef MEM_ACCESS_BOUNDS_EN
    // Out-of-range burst: single error beat, no memory access
    w0 = we_cnt;
    send(1'b0, 8'h7E, 2'd3, 8'h00);
    take("oob", 8'h00, 1'b1, 1'b1, 8'h23, 0, lat);
    check("oob_lat", 32'(lat), 32'd0);
    check("oob_no_write", 32'(we_cnt - w0), 32'd0);
    send(1'b1, 8'h7F, 2'd0, 8'h5A);
    take("edge_wr", 8'h5A, 1'b1, 1'b0, 8'h7F, 0, lat);
    check("edge_wr_count", 32'(we_cnt - w0), 32'd1);
`else
    // Address wrap FE, FF, 00, 01
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'(8'hFE + i), 2'd0, 8'(8'hB0 + i));
      take("wpre", 8'(8'hB0 + i), 1'b1, 1'b0, 8'(8'hFE + i), 0, lat);
    end
    send(1'b0, 8'hFE, 2'd3, 8'h00);
    for (int i = 0; i < 4; i++) begin
      take("wrap", 8'(8'hB0 + i), (i == 3), 1'b0, 8'(8'hFE + i), 0, lat);
    end
`endif

    // Reset during WAIT of a 4-beat read
    w0 = we_cnt;
    send(1'b0, 8'h20, 2'd3, 8'h00);
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mr_rsp_data", 32'(rsp_data), 32'd0);
    check("mr_rsp_last", 32'(rsp_last), 32'd0);
    check("mr_addr", 32'(mem_address), 32'd0);
    check("mr_din", 32'(mem_data_in), 32'd0);
    check("mr_we", 32'(mem_write_enable), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_valid", 32'(rsp_valid), 32'd0);
    send(1'b0, 8'h21, 2'd0, 8'h00);
    take("post_rst_rd", 8'hA1, 1'b1, 1'b0, 8'h21, 0, lat);
    check("post_rst_lat", 32'(lat), 32'(RL + 1));
    check("post_rst_no_write", 32'(we_cnt - w0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
